lamp_monitor: RTL and testbench
===============================

Name: lamp_monitor

Overview:
- Receive-side checker for the 3-bit traffic-lamp output bus (RED=3'b100, GREEN=3'b010, YELLOW=3'b001) driven by the cyclic lamp controller.
- Samples `light` each clock, decodes it to a colour index, and locks onto the R->G->Y cycle.
- Flags illegal codes, out-of-order transitions and stuck colours, and counts completed cycles.
- Sits beside the lamp controller as a watchdog; fault outputs feed the system health/alarm logic.

Parameters:
- STUCK_LIMIT, 4, maximum consecutive samples of one colour before err_stuck; legal range 1..255.
- CNT_W, 8, width of seq_count.

Ports:
- clock  in  1  system clock; all sampling on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear: returns the FSM to SYNC and clears fault and seq_count.
- light  in  [0:2]  lamp bus under observation.
- colour  out  2  registered decode: 0=RED, 1=GREEN, 2=YELLOW, 3=invalid.
- locked  out  1  high while the FSM is in TRACK.
- err_code  out  1  one-cycle pulse: illegal light code seen.
- err_seq  out  1  one-cycle pulse: illegal transition seen.
- err_stuck  out  1  one-cycle pulse: dwell limit exceeded.
- fault  out  1  sticky; set by any error pulse.
- seq_count  out  CNT_W  completed Y->R transitions while locked; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, active-high) values: colour=3, locked=0, all err_* pulses=0, fault=0, seq_count=0, FSM=SYNC, dwell=0, prev colour=invalid.
- Latency: every output reflects the `light` value sampled one rising edge earlier. No combinational path runs from `light` to any output.
- Decode: only the three one-hot codes are legal. 000, 011, 101, 110 and 111 are illegal (colour=3).
- FSM states: SYNC, TRACK, FAULT.
- SYNC:
  - Illegal codes and non-RED colours are ignored; no errors are raised.
  - A RED sample moves to TRACK with prev=RED and dwell=1.
  - The entry RED does not count toward seq_count.
- TRACK, on each sample:
  - Same colour as prev: dwell increments, saturating at STUCK_LIMIT+1. The sample on which dwell becomes STUCK_LIMIT+1 raises err_stuck and moves to FAULT.
  - Legal next colour (R->G, G->Y, Y->R): prev updates and dwell=1. On Y->R, seq_count increments.
  - Any other legal colour change (R->Y, G->R, Y->G): err_seq, then FAULT.
  - Illegal code: err_code, then FAULT.
- FAULT:
  - locked=0; colour keeps decoding live.
  - No further error pulses; seq_count is frozen.
  - Exit only via clr or reset.
- Error priority within a single sample: code > seq > stuck. At most one err_* pulse per cycle.
- fault is set in the same cycle as the first err_* pulse and held until clr or reset.
- clr (synchronous):
  - Next state is SYNC; fault=0, seq_count=0, dwell=0.
  - clr wins over any error detected in the same cycle; no pulse is emitted.
- Reset asserted mid-operation clears everything immediately, independent of clock.
- A controller stepping every clock (dwell=1 per colour) never trips err_stuck for any STUCK_LIMIT>=1.

Optional Feature:
- Macro: LAMP_MONITOR_HIST_EN.
- Defined:
  - Adds output `first_err` (2 bits: 0=none, 1=code, 2=seq, 3=stuck) and output `first_light` [0:2], the raw light value that caused the first fault.
  - Both are captured once per fault episode and cleared by clr/reset.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package lamp_pkg holds:
  - light codes LAMP_RED, LAMP_GREEN, LAMP_YELLOW;
  - colour index constants COL_RED/COL_GREEN/COL_YELLOW/COL_INV;
  - FSM state encoding MON_SYNC/MON_TRACK/MON_FAULT;
  - error codes ERR_NONE/ERR_CODE/ERR_SEQ/ERR_STUCK.
- One combinational sub-module, lamp_decode: maps light[0:2] to a colour index plus a legal flag. The monitor instantiates it once.

Test Plan:
- Reset, then drive R,G,Y repeated 10 times, one per clock -> locked=1 one cycle after the first RED sample; seq_count=9; no err_*; fault=0.
- Locked, then drive light=3'b110 -> err_code pulses for exactly 1 cycle, fault=1, locked=0; seq_count frozen; a following R,G,Y raises no further pulses.
- Locked on GREEN, then drive RED -> err_seq for 1 cycle, fault=1; with HIST_EN: first_err=2, first_light=3'b100.
- STUCK_LIMIT=4: hold RED for 4 samples -> no error; hold for 5 samples -> err_stuck on the 5th sample's output cycle, fault=1.
- FAULT state, assert clr for one cycle while light=3'b000 -> no err_* pulse; fault=0, seq_count=0; state SYNC; relock on the next RED.
- Mid-sequence, assert reset asynchronously between edges -> all outputs immediately at reset values; after release, the first GREEN is ignored until RED arrives.

Source files
------------

// File: rtl/lamp_pkg.sv
// Shared constants for the traffic-lamp receive-side monitor: raw lamp
// codes, decoded colour indices, monitor FSM encoding and first-error codes.
package lamp_pkg;

  // Raw lamp bus codes (one-hot; leftmost bit is light[0])
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;

  // Decoded colour index
  localparam logic [1:0] COL_RED    = 2'd0;
  localparam logic [1:0] COL_GREEN  = 2'd1;
  localparam logic [1:0] COL_YELLOW = 2'd2;
  localparam logic [1:0] COL_INV    = 2'd3;

  // Monitor FSM states
  localparam logic [1:0] MON_SYNC  = 2'd0;
  localparam logic [1:0] MON_TRACK = 2'd1;
  localparam logic [1:0] MON_FAULT = 2'd2;

  // First-error classification
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_CODE  = 2'd1;
  localparam logic [1:0] ERR_SEQ   = 2'd2;
  localparam logic [1:0] ERR_STUCK = 2'd3;

  // Colour that legally follows c in the R->G->Y cycle
  function automatic logic [1:0] col_next(input logic [1:0] c);
    logic [1:0] n;
    case (c)
      COL_RED:    n = COL_GREEN;
      COL_GREEN:  n = COL_YELLOW;
      COL_YELLOW: n = COL_RED;
      default:    n = COL_INV;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lamp_decode.sv
// Combinational lamp-bus decoder: maps the raw 3-bit bus to a colour index
// and flags whether the code is one of the three legal one-hot values.
module lamp_decode
  import lamp_pkg::*;
(
  input  logic [0:2] light,
  output logic [1:0] colour,
  output logic       legal
);

  // Only the three one-hot codes are legal; everything else is COL_INV
  always_comb begin
    colour = COL_INV;
    legal  = 1'b0;
    case (light)
      LAMP_RED:    begin colour = COL_RED;    legal = 1'b1; end
      LAMP_GREEN:  begin colour = COL_GREEN;  legal = 1'b1; end
      LAMP_YELLOW: begin colour = COL_YELLOW; legal = 1'b1; end
      default:     begin colour = COL_INV;    legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/lamp_monitor.sv
// Receive-side watchdog for the cyclic lamp controller. Locks onto the
// R->G->Y cycle, pulses on illegal codes, out-of-order steps and stuck
// colours, keeps a sticky fault and counts completed cycles.
// All outputs are registered: they reflect the sample of the previous edge.
// Optional first-error history ports: define LAMP_MONITOR_HIST_EN.
//
// Handshake: none; light is sampled unconditionally every rising edge and
// the err_* outputs are single-cycle pulses with no acknowledge.
module lamp_monitor
  import lamp_pkg::*;
#(
  parameter int STUCK_LIMIT = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic [0:2]       light,
  output logic [1:0]       colour,
  output logic             locked,
  output logic             err_code,
  output logic             err_seq,
  output logic             err_stuck,
  output logic             fault,
  output logic [CNT_W-1:0] seq_count,
  output logic [1:0]       dbg_state
`ifdef LAMP_MONITOR_HIST_EN
  ,
  output logic [1:0]       first_err,
  output logic [0:2]       first_light
`endif
);

  // Dwell must hold STUCK_LIMIT+1 (up to 256)
  localparam logic [8:0] LIMIT = 9'(STUCK_LIMIT);

  logic [1:0] dec_col;
  logic       dec_legal;

  lamp_decode u_decode (
    .light  (light),
    .colour (dec_col),
    .legal  (dec_legal)
  );

  logic [1:0]       state_q, state_d;
  logic [1:0]       prev_q, prev_d;
  logic [8:0]       dwell_q, dwell_d;
  logic [1:0]       colour_q;
  logic             e_code_q, e_code_d;
  logic             e_seq_q, e_seq_d;
  logic             e_stuck_q, e_stuck_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state logic: clr dominates, then the per-state tracking rules
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    dwell_d   = dwell_q;
    e_code_d  = 1'b0;
    e_seq_d   = 1'b0;
    e_stuck_d = 1'b0;
    fault_d   = fault_q;
    cnt_d     = cnt_q;
    if (clr) begin
      state_d = MON_SYNC;
      prev_d  = COL_INV;
      dwell_d = '0;
      fault_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MON_SYNC: begin
          if (dec_legal && dec_col == COL_RED) begin
            state_d = MON_TRACK;
            prev_d  = COL_RED;
            dwell_d = 9'd1;
          end
        end
        MON_TRACK: begin
          if (!dec_legal) begin
            e_code_d = 1'b1;
            fault_d  = 1'b1;
            state_d  = MON_FAULT;
          end else if (dec_col == prev_q) begin
            dwell_d = dwell_q + 9'd1;
            // Reaching LIMIT+1 is terminal, so the count never exceeds it
            if (dwell_q >= LIMIT) begin
              e_stuck_d = 1'b1;
              fault_d   = 1'b1;
              state_d   = MON_FAULT;
            end
          end else if (dec_col == col_next(prev_q)) begin
            prev_d  = dec_col;
            dwell_d = 9'd1;
            if (prev_q == COL_YELLOW) cnt_d = cnt_q + CNT_W'(1);
          end else begin
            e_seq_d = 1'b1;
            fault_d = 1'b1;
            state_d = MON_FAULT;
          end
        end
        default: begin
          // FAULT: frozen until clr or reset
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= MON_SYNC;
      prev_q    <= COL_INV;
      dwell_q   <= '0;
      colour_q  <= COL_INV;
      e_code_q  <= 1'b0;
      e_seq_q   <= 1'b0;
      e_stuck_q <= 1'b0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      dwell_q   <= dwell_d;
      colour_q  <= dec_col;
      e_code_q  <= e_code_d;
      e_seq_q   <= e_seq_d;
      e_stuck_q <= e_stuck_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef LAMP_MONITOR_HIST_EN
  logic [1:0] ferr_q;
  logic [0:2] flight_q;

  // Capture the cause of the first error of a fault episode
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ferr_q   <= ERR_NONE;
      flight_q <= '0;
    end else if (clr) begin
      ferr_q   <= ERR_NONE;
      flight_q <= '0;
    end else if (!fault_q && (e_code_d || e_seq_d || e_stuck_d)) begin
      ferr_q   <= e_code_d ? ERR_CODE : (e_seq_d ? ERR_SEQ : ERR_STUCK);
      flight_q <= light;
    end
  end

  assign first_err   = ferr_q;
  assign first_light = flight_q;
`endif

  assign colour    = colour_q;
  assign locked    = (state_q == MON_TRACK);
  assign err_code  = e_code_q;
  assign err_seq   = e_seq_q;
  assign err_stuck = e_stuck_q;
  assign fault     = fault_q;
  assign seq_count = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lamp_monitor.sv
// Directed testbench for lamp_monitor (STUCK_LIMIT=4, CNT_W=8).
module tb_lamp_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] G = 3'b010;
  localparam logic [2:0] Y = 3'b001;

  logic       clock;
  logic       reset;
  logic       clr;
  logic [0:2] light;
  logic [1:0] colour;
  logic       locked;
  logic       err_code;
  logic       err_seq;
  logic       err_stuck;
  logic       fault;
  logic [7:0] seq_count;
  logic [1:0] dbg_state;
`ifdef LAMP_MONITOR_HIST_EN
  logic [1:0] first_err;
  logic [0:2] first_light;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];

  lamp_monitor #(.STUCK_LIMIT(4), .CNT_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .clr       (clr),
    .light     (light),
    .colour    (colour),
    .locked    (locked),
    .err_code  (err_code),
    .err_seq   (err_seq),
    .err_stuck (err_stuck),
    .fault     (fault),
    .seq_count (seq_count),
    .dbg_state (dbg_state)
`ifdef LAMP_MONITOR_HIST_EN
    ,
    .first_err   (first_err),
    .first_light (first_light)
`endif
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_colour(input logic [2:0] l);
    case (l)
      3'b100:  return 2'd0;
      3'b010:  return 2'd1;
      3'b001:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Driver: present one sample (optionally with clr), then check decode
  task automatic step(input logic [2:0] l, input logic c);
    light = l;
    clr   = c;
    exp_q.push_back(exp_colour(l));
    @(posedge clock);
    #1;
    chk("colour", 32'(colour), 32'(exp_q.pop_front()));
  endtask

  function automatic logic [31:0] errs();
    return 32'({err_code, err_seq, err_stuck});
  endfunction

  initial begin
    logic [7:0] exp_cnt;
    reset = 1'b1;
    clr   = 1'b0;
    light = 3'b000;
    #2;
    chk("rst_colour", 32'(colour), 32'd3);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_errs", errs(), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cnt", 32'(seq_count), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    #10 reset = 1'b0;

    // Normal cycling: R,G,Y x10
    exp_cnt = 8'd0;
    for (int i = 0; i < 10; i++) begin
      step(R, 1'b0);
      if (i > 0) exp_cnt++;
      chk("run_locked", 32'(locked), 32'd1);
      chk("run_cnt", 32'(seq_count), 32'(exp_cnt));
      step(G, 1'b0);
      chk("run_errs_g", errs(), 32'd0);
      step(Y, 1'b0);
      chk("run_errs_y", errs(), 32'd0);
    end
    chk("run_cnt_end", 32'(seq_count), 32'd9);
    chk("run_fault", 32'(fault), 32'd0);

    // Illegal code while locked
    step(3'b110, 1'b0);
    chk("code_pulse", errs(), 32'b100);
    chk("code_fault", 32'(fault), 32'd1);
    chk("code_locked", 32'(locked), 32'd0);
    chk("code_cnt", 32'(seq_count), 32'd9);
`ifdef LAMP_MONITOR_HIST_EN
    chk("code_ferr", 32'(first_err), 32'd1);
    chk("code_flight", 32'(first_light), 32'(3'b110));
`endif
    step(R, 1'b0);
    chk("code_pulse_end", errs(), 32'd0);
    step(G, 1'b0);
    chk("fault_quiet_g", errs(), 32'd0);
    step(Y, 1'b0);
    chk("fault_quiet_y", errs(), 32'd0);
    chk("fault_hold", 32'(fault), 32'd1);
    chk("fault_cnt", 32'(seq_count), 32'd9);
    chk("fault_state", 32'(dbg_state), 32'd2);

    // clr in FAULT with illegal light
    step(3'b000, 1'b1);
    chk("clr_errs", errs(), 32'd0);
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_cnt", 32'(seq_count), 32'd0);
    chk("clr_state", 32'(dbg_state), 32'd0);
`ifdef LAMP_MONITOR_HIST_EN
    chk("clr_ferr", 32'(first_err), 32'd0);
`endif
    step(G, 1'b0);
    chk("sync_ignore_g", 32'(locked), 32'd0);
    chk("sync_no_err", errs(), 32'd0);
    step(R, 1'b0);
    chk("relock", 32'(locked), 32'd1);

    // Out-of-order G->R
    step(G, 1'b0);
    chk("seq_pre", errs(), 32'd0);
    step(R, 1'b0);
    chk("seq_pulse", errs(), 32'b010);
    chk("seq_fault", 32'(fault), 32'd1);
`ifdef LAMP_MONITOR_HIST_EN
    chk("seq_ferr", 32'(first_err), 32'd2);
    chk("seq_flight", 32'(first_light), 32'(3'b100));
`endif
    step(R, 1'b0);
    chk("seq_pulse_end", errs(), 32'd0);

    // Dwell: 4 REDs legal, 5th trips
    step(3'b000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(R, 1'b0);
      chk("dwell_ok", errs(), 32'd0);
      chk("dwell_locked", 32'(locked), 32'd1);
    end
    step(R, 1'b0);
    chk("stuck_pulse", errs(), 32'b001);
    chk("stuck_fault", 32'(fault), 32'd1);
    chk("stuck_locked", 32'(locked), 32'd0);
`ifdef LAMP_MONITOR_HIST_EN
    chk("stuck_ferr", 32'(first_err), 32'd3);
`endif
    step(R, 1'b0);
    chk("stuck_pulse_end", errs(), 32'd0);

    // clr wins over an illegal code seen while tracking
    step(3'b000, 1'b1);
    step(R, 1'b0);
    step(3'b111, 1'b1);
    chk("clr_win_errs", errs(), 32'd0);
    chk("clr_win_fault", 32'(fault), 32'd0);
    chk("clr_win_state", 32'(dbg_state), 32'd0);

    // Async reset mid-sequence
    step(R, 1'b0);
    step(G, 1'b0);
    step(Y, 1'b0);
    step(R, 1'b0);
    chk("pre_rst_cnt", 32'(seq_count), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_colour", 32'(colour), 32'd3);
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_cnt", 32'(seq_count), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'd0);
    #1 reset = 1'b0;
    step(G, 1'b0);
    chk("post_rst_g", 32'(locked), 32'd0);
    chk("post_rst_errs", errs(), 32'd0);
    step(R, 1'b0);
    chk("post_rst_lock", 32'(locked), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
